// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties unless the previous grant was data, so fetch is never skipped twice.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_f,
  output logic          stall_m,
  output logic [1:0]    fsm_state
);

  // Handshake: a requester raises req with its address/data stable and holds
  // them until its ready pulses for one cycle; on the memory side mem_req stays
  // high with mem_* stable until a one-cycle mem_ack, which ends the access.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_elig;
  logic   d_elig;

  // A requester in its ready cycle is still holding req; it must not be re-granted.
  assign i_elig    = if_req & ~if_ready;
  assign d_elig    = d_req & ~d_ready;
  assign stall_f   = if_req & ~if_ready;
  assign stall_m   = d_req & ~d_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_elig && !(i_elig && last_d)) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_elig) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
            last_d   <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
            last_d  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of solo accesses, hand-written
// sequences for reset, arbitration and spurious acks, memory responder with set latency.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f;
  logic        stall_m;
  logic [1:0]  fsm_state;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters and check ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem_model [logic [31:0]];
  int resp_lat = 0;
  bit resp_hold = 0;
  int spur_req = 0;
  int spur_done = 0;
  int cnt = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : ~a;
  endfunction

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_req && !resp_hold) begin
      if (cnt >= resp_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else mem_rdata = rd(mem_addr);
      end else begin
        cnt++;
      end
    end else if (!mem_req && spur_req != spur_done) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      spur_done++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  int if_ready_cnt = 0;
  int d_ready_cnt = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;
  grant_t grant_log[$];
  logic   mem_req_q = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !mem_req_q) grant_log.push_back({mem_we, mem_addr, mem_wdata});
    mem_req_q = mem_req;
    if (if_ready) begin
      if_ready_cnt++;
      if (if_exp_q.size() == 0) check("if_ready_unexpected", {31'd0, if_ready}, 32'd0);
      else check("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (d_ready) begin
      d_ready_cnt++;
      if (d_exp_q.size() == 0) check("d_ready_unexpected", {31'd0, d_ready}, 32'd0);
      else check("d_rdata", d_rdata, d_exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  logic [31:0] last_load = '0;
  logic [31:0] last_fetch = '0;

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic run_req(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp,
                         input bit solo, input int lat);
    int  c;
    logic rdy;
    logic stl;
    if (is_d) begin
      d_exp_q.push_back(exp);
      if (!we) last_load = exp;
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_exp_q.push_back(exp);
      if_addr = addr; if_req = 1'b1;
    end
    rdy = 1'b0;
    for (c = 0; c < 64; c++) begin
      @(negedge clk);
      rdy = is_d ? d_ready : if_ready;
      stl = is_d ? stall_m : stall_f;
      if (rdy) break;
      if (solo) begin
        check("stall_busy", {31'd0, stl}, 32'd1);
        if (c == 0) begin
          check("mem_req_before_grant", {31'd0, mem_req}, 32'd0);
        end else begin
          check("mem_req_held", {31'd0, mem_req}, 32'd1);
          check("mem_addr_held", mem_addr, addr);
          check("mem_we_held", {31'd0, mem_we}, {31'd0, is_d & we});
          check("mem_wdata_held", mem_wdata, (is_d && we) ? wdata : 32'd0);
        end
      end
    end
    check(is_d ? "d_ready_timeout" : "if_ready_timeout", {31'd0, rdy}, 32'd1);
    if (solo && rdy) begin
      check("latency", c, lat + 2);
      check("stall_in_ready", {31'd0, stl}, 32'd0);
      if (is_d) check("if_rdata_unchanged", if_rdata, last_fetch);
    end
    if (!is_d) last_fetch = exp;
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    if (solo) begin
      @(negedge clk);
      check("ready_single_pulse", {31'd0, is_d ? d_ready : if_ready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [31:0] r_fetch;
    logic [31:0] r_wd;
    int c0;
    grant_t g;
    logic [31:0] exp_addr[6];

    r_fetch = $urandom;
    r_wd    = $urandom;
    mem_model[32'h10]  = 32'h0000_0293;
    mem_model[32'h14]  = 32'h00A0_0513;
    mem_model[32'h104] = 32'h1234_5678;
    mem_model[32'h18]  = r_fetch;
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         0, 32'h0000_0293};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,         5, 32'h00A0_0513};
    vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,         2, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b1, 32'h108, r_wd,          3, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 32'h18,  32'h0, int'($urandom_range(0, 4)), r_fetch};

    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    check("rst_stall_f", {31'd0, stall_f}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Solo accesses with per-cycle checks
    foreach (vecs[i]) begin
      resp_lat = vecs[i].lat;
      run_req(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1, vecs[i].lat);
    end

    // Spurious ack while idle must not produce a ready
    c0 = if_ready_cnt + d_ready_cnt;
    spur_req++;
    repeat (4) @(negedge clk);
    check("spurious_no_ready", if_ready_cnt + d_ready_cnt, c0);
    check("spurious_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a fetch
    resp_hold = 1'b1;
    resp_lat = 0;
    if_addr = 32'h40; if_req = 1'b1;
    @(posedge clk); #1;
    check("mid_mem_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0; if_req = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_state", {30'd0, fsm_state}, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    check("mid_rst_d_rdata", d_rdata, 32'd0);
    check("mid_rst_stall_f", {31'd0, stall_f}, 32'd0);
    last_load = '0; last_fetch = '0;
    @(posedge clk); #1 reset = 1'b1; resp_hold = 1'b0;
    c0 = if_ready_cnt;
    spur_req++;
    repeat (4) @(negedge clk);
    check("post_rst_no_if_ready", if_ready_cnt, c0);
    check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests after reset: data first, then fetch
    grant_log.delete();
    fork
      run_req(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
      run_req(1'b0, 1'b0, 32'h20, 32'h0, rd(32'h20), 1'b0, 0);
    join
    check("sim_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      g = grant_log[0];
      check("sim_g0_we", {31'd0, g.we}, 32'd1);
      check("sim_g0_addr", g.addr, 32'h100);
      check("sim_g0_wdata", g.wdata, 32'hDEAD_BEEF);
      g = grant_log[1];
      check("sim_g1_we", {31'd0, g.we}, 32'd0);
      check("sim_g1_addr", g.addr, 32'h20);
      check("sim_g1_wdata", g.wdata, 32'h0);
    end
    check("sim_d_rdata_zero", d_rdata, 32'h0);

    // Continuous data traffic with fetch pending: strict alternation D,I,D,I,...
    resp_lat = 1;
    grant_log.delete();
    exp_addr = '{32'h200, 32'h30, 32'h204, 32'h34, 32'h208, 32'h38};
    fork
      begin
        run_req(1'b1, 1'b0, 32'h200, 32'h0, rd(32'h200), 1'b0, 1);
        run_req(1'b1, 1'b1, 32'h204, $urandom, last_load, 1'b0, 1);
        run_req(1'b1, 1'b0, 32'h208, 32'h0, rd(32'h208), 1'b0, 1);
      end
      begin
        run_req(1'b0, 1'b0, 32'h30, 32'h0, rd(32'h30), 1'b0, 1);
        run_req(1'b0, 1'b0, 32'h34, 32'h0, rd(32'h34), 1'b0, 1);
        run_req(1'b0, 1'b0, 32'h38, 32'h0, rd(32'h38), 1'b0, 1);
      end
    join
    check("alt_grants", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check($sformatf("alt_g%0d_addr", i), grant_log[i].addr, exp_addr[i]);
    end

    repeat (3) @(negedge clk);
    check("if_queue_drained", if_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the pipelined RV32 core. It shares one single-port unified memory between instruction fetch (IF stage) and data access (MEM stage, lw/sw), sequencing each access through a request/acknowledge protocol. It produces stall requests that the hazard unit turns into StallF/StallD and a full-pipeline freeze. Data accesses win ties, except that fetch is guaranteed the next grant after any data access.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  registered fetch data; valid in the if_ready cycle, held until the next fetch completes
- if_ready  out  1  one-cycle pulse, fetch complete
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  registered load data; updated only on load completion
- d_ready  out  1  one-cycle pulse, data access complete
- mem_req  out  1  memory request, registered; high until mem_ack
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse, at least 1 cycle after mem_req rises
- stall_f  out  1  if_req & ~if_ready (combinational)
- stall_m  out  1  d_req & ~d_ready (combinational)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Register last_d holds 1 if the last completed grant was data.
- IDLE eligibility: a requester is eligible if its req=1 and its ready=0 in the current cycle. This suppresses a re-grant while the requester is dropping or changing its request.
- IDLE with both eligible: grant fetch if last_d=1, otherwise grant data.
- IDLE with one eligible: grant that requester. With none eligible: stay in IDLE.
- On grant, the FSM registers mem_addr/mem_we/mem_wdata from the winner. Fetch forces mem_we=0 and mem_wdata=0. mem_req goes to 1 and the FSM moves to BUSY_I or BUSY_D.
- BUSY_x with mem_ack=1: the FSM clears mem_req and returns to IDLE. It pulses x_ready for the next cycle and captures mem_rdata into if_rdata (fetch) or d_rdata (load only). last_d takes 1 for data and 0 for fetch.
- BUSY_x with mem_ack=0: mem_* outputs are held unchanged. Requester inputs are ignored.
- mem_ack while in IDLE is ignored, with no state change.
- Requester deasserting req while BUSY is a protocol violation. The access still completes and ready still pulses.
- Reset assertion, including mid-transaction, asynchronously forces:
  - state IDLE, last_d=0
  - mem_req/mem_we=0, mem_addr/mem_wdata=0
  - if_ready/d_ready=0, if_rdata/d_rdata=0
  - An in-flight memory access is abandoned.

## Timing
- Grant decision at edge E0. mem_req is high from cycle E0+1.
- mem_ack in cycle C is sampled at the edge ending C. ready is high for exactly the following cycle, together with valid rdata.
- Minimum latency from req sampled to ready is 2 cycles (1-cycle memory).
- A requester may present a new request in the cycle after ready. Back-to-back throughput is one access per 3 cycles with a 1-cycle memory.
- stall_f/stall_m are combinational. They are 0 in any ready cycle and 0 while req=0, including during reset.
- No combinational path from mem_* inputs to any output except through registers.

## Test plan
- Reset mid-access: grant a fetch and assert reset before mem_ack → all outputs 0 and state IDLE immediately. After release, mem_ack is ignored and no if_ready pulses.
- Single fetch, 1-cycle memory:
  - Stimulus: if_addr=0x0000_0010, mem_rdata=0x0000_0293 on mem_ack.
  - Required: mem_req high in cycle 1 with mem_addr=0x10 and mem_we=0; if_ready pulses in cycle 2 with if_rdata=0x293; stall_f=1 in cycles 0–1.
- Simultaneous requests after reset (last_d=0):
  - Stimulus: if_req and d_req both high, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - Required: data granted first (mem_we=1, mem_wdata=0xDEADBEEF), d_ready pulses, d_rdata stays 0; fetch granted next.
- Continuous data requests with fetch pending: grants alternate D, I, D, I. Fetch is never skipped twice in a row.
- Variable latency: mem_ack delayed 5 cycles → mem_* held stable for all 5 cycles and ready pulses exactly once. A spurious mem_ack in IDLE causes no ready pulse.
- Load after store to 0x100: returns mem_rdata=0xDEAD_BEEF in d_rdata, and if_rdata is unchanged across the data access.
